instr_prefetch_unit: RTL and testbench

Parametrised instruction fetch front end with in-order multi-outstanding requests and a DEPTH-entry prefetch queue. Sits between `pc_reg`/`flush_ctrl` and the decode pipeline register, replacing the single-request IDLE/REQUEST/RESPONSE/CONSUME fetch loop. Keeps up to DEPTH requests in flight to instruction memory and hands (pc, instr) pairs to decode with a valid/ready handshake. Discards stale responses after a jump.

---
 rtl/instr_prefetch_unit_pkg.sv | 19 +
 rtl/instr_prefetch_unit_sync_fifo.sv | 61 ++++++
 rtl/instr_prefetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_prefetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_unit_pkg.sv
// Shared constants and types for the instruction prefetch unit.
// Holds the NOP encoding, datapath width, FSM encoding and queue entry layout.
package instr_prefetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        IFU_BOOT = 1'b0,
        IFU_RUN  = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_unit_sync_fifo.sv
// Synchronous FIFO used as the prefetch queue; clear empties it in one cycle.
// Asynchronous active-low reset; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction fetch front end: up to DEPTH in-order requests in flight, prefetch queue to decode.
// Optional same-cycle response bypass to decode is enabled by defining IFU_PREFETCH_BYPASS_EN.
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_in,
    input  logic [31:0]                flush_addr_in,
    output logic                       mem_req_valid_out,
    input  logic                       mem_req_ready_in,
    output logic [31:0]                mem_req_addr_out,
    input  logic                       mem_resp_valid_in,
    input  logic [31:0]                mem_resp_data_in,
    output logic                       id_valid_out,
    input  logic                       id_ready_in,
    output logic [31:0]                id_instr_out,
    output logic [31:0]                id_pc_out,
    output logic [$clog2(DEPTH+1)-1:0] level_out
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    ifu_state_e      state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   disc_cnt_q, disc_cnt_d;

    logic [CW-1:0]   q_cnt;
    logic [CW:0]     inflight;
    logic            running;
    logic            req_fire;
    logic            resp_keep;
    logic            bypass_hit;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_rdata;
    fetch_entry_t    head;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .clear (flush_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_cnt)
    );

    // Credits count both in-flight requests and queued entries, so a response always has room.
    always_comb begin
        running           = (state_q == IFU_RUN);
        inflight          = {1'b0, out_cnt_q} + {1'b0, q_cnt};
        mem_req_valid_out = running && !flush_in && (inflight < DEPTH_C);
        mem_req_addr_out  = fetch_pc_q;
        req_fire          = mem_req_valid_out && mem_req_ready_in;
        resp_keep         = mem_resp_valid_in && (disc_cnt_q == '0);

`ifdef IFU_PREFETCH_BYPASS_EN
        bypass_hit = fifo_empty && resp_keep && !flush_in;
`else
        bypass_hit = 1'b0;
`endif

        head         = fifo_empty ? fetch_entry_t'({resp_pc_q, mem_resp_data_in}) : fifo_rdata;
        id_valid_out = !flush_in && (!fifo_empty || bypass_hit);
        id_instr_out = id_valid_out ? head.instr : INSTR_NOP;
        id_pc_out    = id_valid_out ? head.pc : resp_pc_q;
        level_out    = q_cnt;

        fifo_pop   = id_valid_out && id_ready_in && !fifo_empty;
        fifo_wdata = {resp_pc_q, mem_resp_data_in};
        fifo_push  = resp_keep && !flush_in && !(bypass_hit && id_ready_in)
                     && (!fifo_full || fifo_pop);
    end

    // A flush turns every request still in flight into a response that must be dropped.
    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({req_fire, mem_resp_valid_in})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase

        disc_cnt_d = disc_cnt_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (flush_in) begin
            disc_cnt_d = out_cnt_d;
            fetch_pc_d = flush_addr_in;
            resp_pc_d  = flush_addr_in;
        end else begin
            if (mem_resp_valid_in && (disc_cnt_q != '0)) begin
                disc_cnt_d = disc_cnt_q - CW'(1);
            end
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IFU_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
        end else begin
            state_q    <= IFU_RUN;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: in-order memory model plus a queue-based reference.
// Honours IFU_PREFETCH_BYPASS_EN so the same bench covers both builds.
module tb_instr_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          LW       = $clog2(DEPTH+1);
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFU_PREFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          flush_in;
    logic [31:0]   flush_addr_in;
    logic          mem_req_valid_out;
    logic          mem_req_ready_in;
    logic [31:0]   mem_req_addr_out;
    logic          mem_resp_valid_in;
    logic [31:0]   mem_resp_data_in;
    logic          id_valid_out;
    logic          id_ready_in;
    logic [31:0]   id_instr_out;
    logic [31:0]   id_pc_out;
    logic [LW-1:0] level_out;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } memResp_t;

    entry_t      modelQ[$];
    memResp_t    pendQ[$];
    logic [31:0] mFetchPc;
    logic [31:0] mRespPc;
    int          mOut;
    int          mDisc;
    int          cycle;
    int          errors;
    int          checks;

    instr_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_in          (flush_in),
        .flush_addr_in     (flush_addr_in),
        .mem_req_valid_out (mem_req_valid_out),
        .mem_req_ready_in  (mem_req_ready_in),
        .mem_req_addr_out  (mem_req_addr_out),
        .mem_resp_valid_in (mem_resp_valid_in),
        .mem_resp_data_in  (mem_resp_data_in),
        .id_valid_out      (id_valid_out),
        .id_ready_in       (id_ready_in),
        .id_instr_out      (id_instr_out),
        .id_pc_out         (id_pc_out),
        .level_out         (level_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Drives one cycle at the falling edge, checks the settled outputs, then advances the model.
    task automatic applyStimulus(input logic f, input logic [31:0] fa, input logic rdy,
                                 input logic idr, input int lat);
        logic   respV;
        logic   expReqV;
        logic   expIdV;
        logic   bypassHit;
        logic   accept;
        entry_t head;
        @(negedge clk);
        respV             = (pendQ.size() > 0) && (pendQ[0].due <= cycle);
        flush_in          = f;
        flush_addr_in     = fa;
        mem_req_ready_in  = rdy;
        id_ready_in       = idr;
        mem_resp_valid_in = respV;
        mem_resp_data_in  = respV ? pendQ[0].data : $urandom;
        #1;
        expReqV   = (cycle >= 1) && !f && ((mOut + modelQ.size()) < DEPTH);
        bypassHit = BYPASS && (modelQ.size() == 0) && (mDisc == 0) && respV && !f;
        expIdV    = !f && ((modelQ.size() > 0) || bypassHit);
        if (modelQ.size() > 0) head = modelQ[0];
        else                   head = '{pc: mRespPc, instr: mem_resp_data_in};

        checkOutput("req_valid", 32'(mem_req_valid_out), 32'(expReqV));
        checkOutput("req_addr", mem_req_addr_out, mFetchPc);
        checkOutput("id_valid", 32'(id_valid_out), 32'(expIdV));
        checkOutput("level", 32'(level_out), 32'(modelQ.size()));
        if (expIdV) begin
            checkOutput("id_instr", id_instr_out, head.instr);
            checkOutput("id_pc", id_pc_out, head.pc);
        end else begin
            checkOutput("id_instr_nop", id_instr_out, NOP);
        end

        accept = expReqV && rdy;
        if (accept) pendQ.push_back('{data: memData(mFetchPc), due: cycle + lat});
        if (respV) pendQ.pop_front();
        if (f) begin
            modelQ.delete();
            mOut     = mOut + int'(accept) - int'(respV);
            mDisc    = mOut;
            mFetchPc = fa;
            mRespPc  = fa;
        end else begin
            if (accept) begin
                mFetchPc = mFetchPc + 32'd4;
                mOut++;
            end
            if (expIdV && idr && (modelQ.size() > 0)) modelQ.pop_front();
            if (respV) begin
                mOut--;
                if (mDisc > 0) begin
                    mDisc--;
                end else begin
                    if (!(bypassHit && idr)) modelQ.push_back('{pc: mRespPc, instr: mem_resp_data_in});
                    mRespPc = mRespPc + 32'd4;
                end
            end
        end
        cycle++;
    endtask

    // Resets DUT, memory and model together; releases reset just after a rising edge.
    task automatic doReset();
        @(negedge clk);
        rst               = 1'b0;
        flush_in          = 1'b0;
        mem_req_ready_in  = 1'b0;
        mem_resp_valid_in = 1'b0;
        id_ready_in       = 1'b0;
        pendQ.delete();
        modelQ.delete();
        mOut     = 0;
        mDisc    = 0;
        mFetchPc = RESET_PC;
        mRespPc  = RESET_PC;
        #1;
        checkOutput("rst_req_valid", 32'(mem_req_valid_out), 32'd0);
        checkOutput("rst_req_addr", mem_req_addr_out, RESET_PC);
        checkOutput("rst_id_valid", 32'(id_valid_out), 32'd0);
        checkOutput("rst_id_instr", id_instr_out, NOP);
        checkOutput("rst_id_pc", id_pc_out, RESET_PC);
        checkOutput("rst_level", 32'(level_out), 32'd0);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        cycle = 0;
    endtask

    initial begin
        bit          found;
        logic        f;
        logic [31:0] fa;
        errors            = 0;
        checks            = 0;
        cycle             = 0;
        rst               = 1'b0;
        flush_in          = 1'b0;
        flush_addr_in     = '0;
        mem_req_ready_in  = 1'b0;
        mem_resp_valid_in = 1'b0;
        mem_resp_data_in  = '0;
        id_ready_in       = 1'b0;
        doReset();

        // Streaming with 1-cycle memory latency, pinned against hand-computed values.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1);
            if (i == 0) checkOutput("lit_boot_noreq", 32'(mem_req_valid_out), 32'd0);
            if (i == 1) begin
                checkOutput("lit_req1_valid", 32'(mem_req_valid_out), 32'd1);
                checkOutput("lit_req1_addr", mem_req_addr_out, 32'h0);
            end
            if (i == 2) begin
                checkOutput("lit_req2_addr", mem_req_addr_out, 32'h4);
                checkOutput("lit_c2_id_valid", 32'(id_valid_out), BYPASS ? 32'd1 : 32'd0);
            end
            if (i == 3) begin
                checkOutput("lit_req3_addr", mem_req_addr_out, 32'h8);
                checkOutput("lit_c3_id_pc", id_pc_out, BYPASS ? 32'h4 : 32'h0);
            end
            if (i == 5) checkOutput("lit_c5_id_pc", id_pc_out, BYPASS ? 32'hC : 32'h8);
        end

        // Decode stall fills the queue and stops issue; one pop resumes issue a cycle later.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1);
        checkOutput("lit_stall_level", 32'(level_out), 32'd4);
        checkOutput("lit_stall_noreq", 32'(mem_req_valid_out), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1);
        checkOutput("lit_pop_still_noreq", 32'(mem_req_valid_out), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1);
        checkOutput("lit_resume_req", 32'(mem_req_valid_out), 32'd1);

        // Memory refuses requests; address must hold.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1);

        // Build up outstanding requests with a slow memory, then redirect to 0x100.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 4);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2);
            if (id_valid_out) begin
                found = 1'b1;
                checkOutput("lit_flush_pc", id_pc_out, 32'h100);
                checkOutput("lit_flush_instr", id_instr_out, memData(32'h100));
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL flush_timeout: got no id_valid expected one within 20 cycles");
        end

        // Randomized traffic with flushes, wrap-around targets and one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            f  = ($urandom_range(0, 24) == 0);
            fa = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(f, fa, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
                          $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
